// File: rtl/rle_ctrl_if.sv
// Handshake/config bundle between a capture host and the RLE controller.
// The host drives the master side; the controller drives the slave side.
interface rle_ctrl_if #(
   parameter int KW = 4,
   parameter int CW = 32
);
   logic          cfg_rle;
   logic [1:0]    cfg_mode;
   logic [KW-1:0] cfg_groups;
   logic [CW-1:0] max_words;
   logic          cmd_arm;
   logic          cmd_abort;
   logic          trig_stop;
   logic          sto_valid;
   logic          rle_enable;
   logic          rle_arm;
   logic [1:0]    rle_mode;
   logic [KW-1:0] rle_groups;
   logic          busy;
   logic          done;
   logic          err;
   logic [CW-1:0] word_cnt;

   modport master (
      output cfg_rle, cfg_mode, cfg_groups, max_words,
      output cmd_arm, cmd_abort, trig_stop, sto_valid,
      input  rle_enable, rle_arm, rle_mode, rle_groups,
      input  busy, done, err, word_cnt
   );

   modport slave (
      input  cfg_rle, cfg_mode, cfg_groups, max_words,
      input  cmd_arm, cmd_abort, trig_stop, sto_valid,
      output rle_enable, rle_arm, rle_mode, rle_groups,
      output busy, done, err, word_cnt
   );
endinterface

// File: rtl/rle_ctrl.sv
// Capture sequencer for an RLE encoder: arms it, counts its output words,
// and runs a fixed-length flush so the encoder can emit its pending run.
module rle_ctrl #(
   parameter int KW        = 4,
   parameter int CW        = 32,
   parameter int FLUSH_CYC = 4
) (
   input logic         clk,
   input logic         rst_n,
   rle_ctrl_if.slave   bus
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [3:0]    FLUSH_LD = 4'(FLUSH_CYC);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   state_t        r_state, w_next;
   logic [3:0]    r_flush, w_flush_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic          r_cfg_rle;
   logic [1:0]    r_mode;
   logic [KW-1:0] r_groups;
   logic          r_en, r_arm, r_busy, r_done, r_err;
   logic          w_en, w_arm, w_busy, w_done;
   logic          w_active, w_arm_ok, w_arm_bad, w_limit;

   assign w_active  = (r_state == S_RUN) || (r_state == S_FLUSH);
   assign w_arm_ok  = bus.cmd_arm && !bus.cmd_abort && !w_active && !(&bus.cfg_groups);
   assign w_arm_bad = bus.cmd_arm && !bus.cmd_abort && !w_active && (&bus.cfg_groups);
   assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);

   // Abort freezes the count; the limit compare looks at the post-increment value.
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_arm_ok)
         w_cnt_nxt = '0;
      else if (w_active && bus.sto_valid && !bus.cmd_abort)
         w_cnt_nxt = w_cnt_inc;
   end

   assign w_limit = (bus.max_words != '0) && (w_cnt_nxt >= bus.max_words);

   always_comb begin
      w_next      = r_state;
      w_flush_nxt = r_flush;
      if (bus.cmd_abort) begin
         w_next      = S_IDLE;
         w_flush_nxt = '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: if (w_arm_ok) w_next = S_RUN;
            S_RUN: begin
               if (bus.trig_stop || w_limit) begin
                  w_next      = S_FLUSH;
                  w_flush_nxt = FLUSH_LD;
               end
            end
            S_FLUSH: begin
               w_flush_nxt = (r_flush == 4'd0) ? 4'd0 : r_flush - 4'd1;
               if (r_flush <= 4'd1) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state and registered alongside it.
   always_comb begin
      w_arm  = (w_next == S_RUN) || (w_next == S_FLUSH);
      w_busy = w_arm;
      w_done = (w_next == S_DONE);
      w_en   = (w_next == S_RUN) && (w_arm_ok ? bus.cfg_rle : r_cfg_rle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_flush   <= '0;
         r_cnt     <= '0;
         r_cfg_rle <= 1'b0;
         r_mode    <= '0;
         r_groups  <= '0;
         r_en      <= 1'b0;
         r_arm     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state <= w_next;
         r_flush <= w_flush_nxt;
         r_cnt   <= w_cnt_nxt;
         r_en    <= w_en;
         r_arm   <= w_arm;
         r_busy  <= w_busy;
         r_done  <= w_done;
         if (w_arm_ok) begin
            r_cfg_rle <= bus.cfg_rle;
            r_mode    <= bus.cfg_mode;
            r_groups  <= bus.cfg_groups;
            r_err     <= 1'b0;
         end else if (w_arm_bad) begin
            r_err <= 1'b1;
         end
      end
   end

   assign bus.rle_enable = r_en;
   assign bus.rle_arm    = r_arm;
   assign bus.rle_mode   = r_mode;
   assign bus.rle_groups = r_groups;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.err        = r_err;
   assign bus.word_cnt   = r_cnt;
endmodule
